// File: rtl/sgpio_pkg.sv
// Shared constants and FSM state encoding for the SGPIO initiator.
package sgpio_pkg;
  localparam int BITS_PER_DRIVE = 3;
  localparam int FLD_ACT        = 0;
  localparam int FLD_LOC        = 1;
  localparam int FLD_FAIL       = 2;
  localparam int VENDOR_BITS    = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } sgpio_state_e;
endpackage

// File: rtl/sgpio_clk_gen.sv
// SClock divider: toggles ck every CLK_DIV cycles while run is high, parked low otherwise.
module sgpio_clk_gen #(
  parameter int CLK_DIV = 125
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic ck,
  output logic ck_rise,
  output logic ck_fall
);
  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt;
  logic             tick;

  // Strobes mark the SYSCLK edge on which ck is about to change level.
  assign tick    = run && (cnt == '0);
  assign ck_rise = tick && !ck;
  assign ck_fall = tick && ck;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= RELOAD;
      ck  <= 1'b0;
    end else if (!run) begin
      cnt <= RELOAD;
      ck  <= 1'b0;
    end else if (tick) begin
      cnt <= RELOAD;
      ck  <= ~ck;
    end else begin
      cnt <= cnt - CNT_W'(1);
    end
  end
endmodule

// File: rtl/sgpio_initiator.sv
// SFF-8485 SGPIO initiator: serialises per-drive ACT/LOC/FAIL bits as continuous frames.
// Optional SDataIn capture is enabled with `define SGPIO_SDATAIN_EN.
module sgpio_initiator
  import sgpio_pkg::*;
#(
  parameter int NUM_DRIVES = 36,
  parameter int CLK_DIV    = 125
) (
  input  logic                           SYSCLK,
  input  logic                           RESET,
  input  logic                           EN,
  input  logic [NUM_DRIVES-1:0]          DRV_ACT,
  input  logic [NUM_DRIVES-1:0]          DRV_LOC,
  input  logic [NUM_DRIVES-1:0]          DRV_FAIL,
  input  logic [VENDOR_BITS-1:0]         VENDOR,
  output logic                           SGPIO_CK,
  output logic                           SGPIO_LD,
  output logic                           SGPIO_DATA,
  output logic                           BUSY,
  output logic                           FRAME_DONE
`ifdef SGPIO_SDATAIN_EN
  ,
  input  logic                           SGPIO_DIN,
  output logic [BITS_PER_DRIVE*NUM_DRIVES-1:0] DRV_IN
`endif
);
  localparam int FL  = BITS_PER_DRIVE * NUM_DRIVES;
  localparam int K_W = $clog2(FL);
  localparam logic [K_W-1:0] K_LAST = K_W'(FL - 1);

  sgpio_state_e           state;
  logic [K_W-1:0]         k;
  logic [FL-1:0]          data_sh;
  logic [VENDOR_BITS-1:0] ven_sh;
  logic [FL-1:0]          frame_now;
  logic                   ck_rise, ck_fall;
  logic                   frame_end, start;

  function automatic logic [FL-1:0] pack_frame(
    input logic [NUM_DRIVES-1:0] act,
    input logic [NUM_DRIVES-1:0] loc,
    input logic [NUM_DRIVES-1:0] fail
  );
    logic [FL-1:0] f;
    f = '0;
    for (int d = 0; d < NUM_DRIVES; d++) begin
      f[BITS_PER_DRIVE*d + FLD_ACT]  = act[d];
      f[BITS_PER_DRIVE*d + FLD_LOC]  = loc[d];
      f[BITS_PER_DRIVE*d + FLD_FAIL] = fail[d];
    end
    return f;
  endfunction

  assign frame_now = pack_frame(DRV_ACT, DRV_LOC, DRV_FAIL);
  assign frame_end = ck_fall && (k == K_LAST);
  // A new frame starts either from IDLE or back-to-back on the closing falling edge.
  assign start     = EN && ((state == IDLE) || frame_end);

  sgpio_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
    .clk     (SYSCLK),
    .rst     (RESET),
    .run     (state == SHIFT),
    .ck      (SGPIO_CK),
    .ck_rise (ck_rise),
    .ck_fall (ck_fall)
  );

  // Frame FSM and registered LD/DATA, updated only on SClock falling edges.
  always_ff @(posedge SYSCLK or posedge RESET) begin
    if (RESET) begin
      state      <= IDLE;
      k          <= '0;
      BUSY       <= 1'b0;
      FRAME_DONE <= 1'b0;
      SGPIO_LD   <= 1'b0;
      SGPIO_DATA <= 1'b0;
    end else begin
      FRAME_DONE <= frame_end;
      if (start) begin
        state      <= SHIFT;
        k          <= '0;
        BUSY       <= 1'b1;
        SGPIO_LD   <= 1'b1;
        SGPIO_DATA <= frame_now[0];
      end else if (frame_end) begin
        state      <= IDLE;
        k          <= '0;
        BUSY       <= 1'b0;
        SGPIO_LD   <= 1'b0;
        SGPIO_DATA <= 1'b0;
      end else if (ck_fall) begin
        k          <= k + K_W'(1);
        SGPIO_LD   <= (k < K_W'(VENDOR_BITS)) ? ven_sh[0] : 1'b0;
        SGPIO_DATA <= data_sh[0];
      end
    end
  end

  // Shadow of the frame being sent; bit 0 goes straight to SGPIO_DATA at start.
  always_ff @(posedge SYSCLK) begin
    if (start) begin
      data_sh <= frame_now >> 1;
      ven_sh  <= VENDOR;
    end else if (ck_fall) begin
      data_sh <= data_sh >> 1;
      ven_sh  <= ven_sh >> 1;
    end
  end

`ifdef SGPIO_SDATAIN_EN
  logic [FL-1:0] capture;

  always_ff @(posedge SYSCLK) begin
    if (ck_rise) capture[k] <= SGPIO_DIN;
  end

  // Only a completed frame publishes its capture.
  always_ff @(posedge SYSCLK or posedge RESET) begin
    if (RESET)          DRV_IN <= '0;
    else if (frame_end) DRV_IN <= capture;
  end
`endif
endmodule

// File: tb/tb_sgpio_initiator.sv
// Scoreboard bench for sgpio_initiator (NUM_DRIVES=2, CLK_DIV=2); define SGPIO_SDATAIN_EN for capture tests.
module tb_sgpio_initiator;
  localparam int ND = 2;
  localparam int CD = 2;
  localparam int FL = 6;

  logic          sysclk;
  logic          reset;
  logic          en;
  logic [ND-1:0] drv_act, drv_loc, drv_fail;
  logic [3:0]    vendor;
  logic          sgpio_ck, sgpio_ld, sgpio_data, busy, frame_done;
`ifdef SGPIO_SDATAIN_EN
  logic          sgpio_din;
  logic [FL-1:0] drv_in;
`endif

  int tests  = 0;
  int failed = 0;
  int cyc    = 0;
  logic [1:0] exp_q[$];
  logic [1:0] exp_bit;
  logic       prev_ck = 1'b0;

  sgpio_initiator #(.NUM_DRIVES(ND), .CLK_DIV(CD)) dut (
    .SYSCLK     (sysclk),
    .RESET      (reset),
    .EN         (en),
    .DRV_ACT    (drv_act),
    .DRV_LOC    (drv_loc),
    .DRV_FAIL   (drv_fail),
    .VENDOR     (vendor),
    .SGPIO_CK   (sgpio_ck),
    .SGPIO_LD   (sgpio_ld),
    .SGPIO_DATA (sgpio_data),
    .BUSY       (busy),
    .FRAME_DONE (frame_done)
`ifdef SGPIO_SDATAIN_EN
    ,
    .SGPIO_DIN  (sgpio_din),
    .DRV_IN     (drv_in)
`endif
  );

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;
  always @(posedge sysclk) cyc++;

  // Receiver model: every SClock rise consumes one expected {LD,DATA} pair.
  always @(negedge sysclk) begin
    if (!prev_ck && sgpio_ck === 1'b1) begin
      tests++;
      if (exp_q.size() == 0) begin
        failed++;
        $display("FAIL unexpected_bit: got ld=%b data=%b, none expected", sgpio_ld, sgpio_data);
      end else begin
        exp_bit = exp_q.pop_front();
        if ({sgpio_ld, sgpio_data} !== exp_bit) begin
          failed++;
          $display("FAIL frame_bit: got ld=%b data=%b, want ld=%b data=%b",
                   sgpio_ld, sgpio_data, exp_bit[1], exp_bit[0]);
        end
      end
    end
    prev_ck = (sgpio_ck === 1'b1);
  end

  task automatic push_frame(input logic [ND-1:0] act, input logic [ND-1:0] loc,
                            input logic [ND-1:0] fail, input logic [3:0] ven, input int nbits);
    int d, f;
    logic dbit, lbit;
    for (int b = 0; b < nbits; b++) begin
      d = b / 3;
      f = b % 3;
      dbit = (f == 0) ? act[d] : (f == 1) ? loc[d] : fail[d];
      if (b == 0)      lbit = 1'b1;
      else if (b <= 4) lbit = ven[b-1];
      else             lbit = 1'b0;
      exp_q.push_back({lbit, dbit});
    end
  endtask

  task automatic wait_busy(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(negedge sysclk);
      if (busy === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge sysclk);
      if (frame_done === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; en = 1'b0;
    drv_act = '0; drv_loc = '0; drv_fail = '0; vendor = '0;
`ifdef SGPIO_SDATAIN_EN
    sgpio_din = 1'b0;
`endif
    repeat (3) @(negedge sysclk);
    tests++;
    if ({sgpio_ck, sgpio_ld, sgpio_data, busy, frame_done} !== 5'b0) begin
      failed++;
      $display("FAIL reset_outputs: got %b, want 00000",
               {sgpio_ck, sgpio_ld, sgpio_data, busy, frame_done});
    end
`ifdef SGPIO_SDATAIN_EN
    tests++;
    if (drv_in !== '0) begin
      failed++;
      $display("FAIL reset_drv_in: got %b, want 000000", drv_in);
    end
`endif
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge sysclk);
      tests++;
      if (sgpio_ck !== 1'b0 || busy !== 1'b0) begin
        failed++;
        $display("FAIL idle_static: got ck=%b busy=%b, want 0 0", sgpio_ck, busy);
      end
    end
  endtask

  task automatic test_frames;
    bit ok;
    int t0, t1;
    drv_act = 2'b01; drv_loc = 2'b10; drv_fail = 2'b00; vendor = 4'b1010;
    push_frame(2'b01, 2'b10, 2'b00, 4'b1010, FL);
    en = 1'b1;
    wait_busy(ok);
    tests++;
    if (!ok) begin failed++; $display("FAIL start_busy: got busy=%b, want 1", busy); end
    t0 = cyc;
    tests++;
    if (sgpio_ld !== 1'b1 || sgpio_ck !== 1'b0) begin
      failed++;
      $display("FAIL k0_levels: got ld=%b ck=%b, want ld=1 ck=0", sgpio_ld, sgpio_ck);
    end
    repeat (9) @(negedge sysclk);
    drv_act = 2'b11;
    push_frame(2'b11, 2'b10, 2'b00, 4'b1010, FL);
    wait_done(ok);
    t1 = cyc;
    tests++;
    if (!ok || t1 - t0 != 24) begin
      failed++;
      $display("FAIL frame1_length: got %0d cycles (done=%b), want 24", t1 - t0, ok);
    end
    repeat (13) @(negedge sysclk);
    en = 1'b0;
    wait_done(ok);
    tests++;
    if (!ok || cyc - t1 != 24) begin
      failed++;
      $display("FAIL frame2_length: got %0d cycles (done=%b), want 24", cyc - t1, ok);
    end
    @(negedge sysclk);
    tests++;
    if ({frame_done, sgpio_ck, sgpio_ld, sgpio_data, busy} !== 5'b0) begin
      failed++;
      $display("FAIL idle_after_frame: got done,ck,ld,data,busy=%b, want 00000",
               {frame_done, sgpio_ck, sgpio_ld, sgpio_data, busy});
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge sysclk);
      tests++;
      if (sgpio_ck !== 1'b0 || busy !== 1'b0) begin
        failed++;
        $display("FAIL stays_idle: got ck=%b busy=%b, want 0 0", sgpio_ck, busy);
      end
    end
    tests++;
    if (exp_q.size() != 0) begin
      failed++;
      $display("FAIL frames_consumed: got %0d bits pending, want 0", exp_q.size());
    end
  endtask

`ifdef SGPIO_SDATAIN_EN
  task automatic test_capture;
    bit ok;
    drv_act = 2'b10; drv_loc = 2'b01; drv_fail = 2'b11; vendor = 4'b0101;
    push_frame(2'b10, 2'b01, 2'b11, 4'b0101, FL);
    sgpio_din = 1'b0;
    en = 1'b1;
    wait_busy(ok);
    repeat (16) @(negedge sysclk);
    sgpio_din = 1'b1;
    repeat (4) @(negedge sysclk);
    sgpio_din = 1'b0;
    en = 1'b0;
    wait_done(ok);
    tests++;
    if (!ok || drv_in !== 6'b010000) begin
      failed++;
      $display("FAIL capture_bit4: got %b (done=%b), want 010000", drv_in, ok);
    end
    repeat (4) @(negedge sysclk);
  endtask
`endif

  task automatic test_reset_abort;
    bit ok;
    int t0;
    drv_act = 2'b01; drv_loc = 2'b10; drv_fail = 2'b00; vendor = 4'b1010;
    push_frame(2'b01, 2'b10, 2'b00, 4'b1010, 3);
    en = 1'b1;
`ifdef SGPIO_SDATAIN_EN
    sgpio_din = 1'b1;
`endif
    wait_busy(ok);
    repeat (13) @(negedge sysclk);
`ifdef SGPIO_SDATAIN_EN
    tests++;
    if (drv_in !== 6'b010000) begin
      failed++;
      $display("FAIL drv_in_midframe: got %b, want 010000", drv_in);
    end
`endif
    reset = 1'b1;
    #1;
    tests++;
    if ({sgpio_ck, sgpio_ld, sgpio_data, busy, frame_done} !== 5'b0) begin
      failed++;
      $display("FAIL async_reset: got %b, want 00000",
               {sgpio_ck, sgpio_ld, sgpio_data, busy, frame_done});
    end
`ifdef SGPIO_SDATAIN_EN
    tests++;
    if (drv_in !== '0) begin
      failed++;
      $display("FAIL abort_drv_in: got %b, want 000000", drv_in);
    end
`endif
    for (int i = 0; i < 2; i++) begin
      @(negedge sysclk);
      tests++;
      if (frame_done !== 1'b0) begin
        failed++;
        $display("FAIL abort_no_done: got %b, want 0", frame_done);
      end
    end
    tests++;
    if (exp_q.size() != 0) begin
      failed++;
      $display("FAIL abort_bits: got %0d bits pending, want 0", exp_q.size());
    end
    push_frame(2'b01, 2'b10, 2'b00, 4'b1010, FL);
`ifdef SGPIO_SDATAIN_EN
    sgpio_din = 1'b0;
`endif
    reset = 1'b0;
    wait_busy(ok);
    t0 = cyc;
    tests++;
    if (!ok || sgpio_ld !== 1'b1) begin
      failed++;
      $display("FAIL restart_k0: got busy_ok=%b ld=%b, want 1 1", ok, sgpio_ld);
    end
    en = 1'b0;
    wait_done(ok);
    tests++;
    if (!ok || cyc - t0 != 24) begin
      failed++;
      $display("FAIL restart_length: got %0d cycles (done=%b), want 24", cyc - t0, ok);
    end
    repeat (3) @(negedge sysclk);
    tests++;
    if (exp_q.size() != 0 || busy !== 1'b0) begin
      failed++;
      $display("FAIL restart_end: got pending=%0d busy=%b, want 0 0", exp_q.size(), busy);
    end
  endtask

  initial begin
    test_reset();
    test_frames();
`ifdef SGPIO_SDATAIN_EN
    test_capture();
`endif
    test_reset_abort();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, want finish before 200000");
    $fatal(1, "watchdog expired");
  end
endmodule
